cache_control: RTL



---
 rtl/cache_types.sv | 26 ++
 rtl/cache_control.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cache_types.sv
// Shared types and constants for the L1 cache controller and its datapath.
package cache_types;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    CHECK     = 2'b01,
    WRITEBACK = 2'b10,
    FILL      = 2'b11
  } cache_state_t;

  // Data-array write source select.
  localparam logic [1:0] WSEL_NONE = 2'b00;
  localparam logic [1:0] WSEL_PMEM = 2'b01;
  localparam logic [1:0] WSEL_CPU  = 2'b10;

  // Physical-memory address source select.
  localparam logic PADDR_VICTIM = 1'b0;
  localparam logic PADDR_CPU    = 1'b1;

  // One-hot per-way strobe for a 2-way cache.
  function automatic logic [1:0] way_onehot(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction

endpackage : cache_types

// File: rtl/cache_control.sv
// Control FSM for the 2-way, 8-set, 32-byte-line L1 cache. Serves one CPU
// request at a time: hit check, optional dirty-victim write-back, line fill,
// then a re-check that completes the request.
module cache_control
  import cache_types::*;
(
  input  logic       clk,
  input  logic       rst,

  // CPU side
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,

  // Datapath status
  input  logic [1:0] cache_hit,
  input  logic       write_back,
  input  logic       way,
  input  logic       way_reg,

  // Datapath control
  output logic       load_way_reg,
  output logic       way_sel,
  output logic [1:0] write_sel,
  output logic [1:0] load_tag,
  output logic [1:0] load_valid,
  output logic [1:0] load_dirty,
  output logic       set_valid,
  output logic       set_dirty,
  output logic       set_lru,
  output logic       load_lru,
  output logic       pmem_addr_sel,

  // Physical-memory side
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp
);

  cache_state_t state_q;
  cache_state_t state_d;

  logic request;
  logic hit;

  assign request = mem_read | mem_write;
  assign hit     = |cache_hit;

  // State register with synchronous reset to IDLE.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_d,
    // so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (request) state_d = CHECK;
      end
      CHECK: begin
        if (!request)       state_d = IDLE;
        else if (hit)       state_d = IDLE;
        else if (write_back) state_d = WRITEBACK;
        else                state_d = FILL;
      end
      WRITEBACK: begin
        if (pmem_resp) state_d = FILL;
      end
      FILL: begin
        if (pmem_resp) state_d = CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is held.
  always_comb begin
    mem_resp      = 1'b0;
    load_way_reg  = 1'b0;
    way_sel       = 1'b0;
    write_sel     = WSEL_NONE;
    load_tag      = 2'b00;
    load_valid    = 2'b00;
    load_dirty    = 2'b00;
    set_valid     = 1'b0;
    set_dirty     = 1'b0;
    set_lru       = 1'b0;
    load_lru      = 1'b0;
    pmem_addr_sel = PADDR_VICTIM;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;

    if (!rst) begin
      unique case (state_q)
        IDLE: begin
          // Waiting for a request; the data arrays read during this cycle.
        end
        CHECK: begin
          if (request && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            set_lru  = ~way;
            // A write wins when both request lines are high.
            if (mem_write) begin
              way_sel    = way;
              write_sel  = WSEL_CPU;
              load_dirty = way_onehot(way);
              set_dirty  = 1'b1;
            end
          end else if (request) begin
            load_way_reg = 1'b1;
          end
        end
        WRITEBACK: begin
          way_sel       = way_reg;
          pmem_addr_sel = PADDR_VICTIM;
          pmem_write    = 1'b1;
          if (pmem_resp) begin
            load_dirty = way_onehot(way_reg);
            set_dirty  = 1'b0;
          end
        end
        FILL: begin
          way_sel       = way_reg;
          pmem_addr_sel = PADDR_CPU;
          pmem_read     = 1'b1;
          if (pmem_resp) begin
            write_sel  = WSEL_PMEM;
            load_tag   = way_onehot(way_reg);
            load_valid = way_onehot(way_reg);
            set_valid  = 1'b1;
            load_dirty = way_onehot(way_reg);
            set_dirty  = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule : cache_control
